// File: rtl/router_drain_scheduler_if.sv
// Output-side bus of the router drain scheduler: FIFO status/heads in, pop strobes
// and the shared single-byte valid/ready stream out.
interface router_drain_scheduler_if;
    logic [2:0] vldout;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic [7:0] data_out_2;
    logic [2:0] read_enb;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;
    logic [2:0] soft_reset;

    modport master (
        input  vldout, data_out_0, data_out_1, data_out_2, out_ready,
        output read_enb, out_data, out_valid, out_chan, soft_reset
    );

    modport slave (
        output vldout, data_out_0, data_out_1, data_out_2, out_ready,
        input  read_enb, out_data, out_valid, out_chan, soft_reset
    );
endinterface

// File: rtl/router_drain_scheduler.sv
// Round-robin burst drain of three router FIFOs onto one valid/ready byte stream,
// with a per-channel starvation watchdog.
module router_drain_scheduler #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned TIMEOUT   = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    router_drain_scheduler_if.master bus
);
    typedef enum logic [1:0] {StIdle = 2'd0, StXfer = 2'd1, StGap = 2'd2} state_e;

    localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);
    localparam logic [7:0] WdLast    = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;
    logic [2:0][7:0] wd_cnt_q, wd_cnt_d;
    logic [2:0]      soft_reset_q, soft_reset_d;

    logic [1:0] c1, c2, c3, rr_chan;
    logic       vld_g;
    logic [7:0] head_g;
    logic       out_valid;
    logic [2:0] read_enb;

    // Candidate order for the next grant, starting just after the last one served.
    always_comb begin
        c1 = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        c3 = (c2 == 2'd2) ? 2'd0 : c2 + 2'd1;
        if (bus.vldout[c1]) begin
            rr_chan = c1;
        end else if (bus.vldout[c2]) begin
            rr_chan = c2;
        end else begin
            rr_chan = c3;
        end
    end

    always_comb begin
        vld_g  = 1'b0;
        head_g = 8'h00;
        case (grant_q)
            2'd0:    begin vld_g = bus.vldout[0]; head_g = bus.data_out_0; end
            2'd1:    begin vld_g = bus.vldout[1]; head_g = bus.data_out_1; end
            2'd2:    begin vld_g = bus.vldout[2]; head_g = bus.data_out_2; end
            default: begin vld_g = 1'b0;          head_g = 8'h00;          end
        endcase
    end

    always_comb begin
        out_valid = (state_q == StXfer) && vld_g;
        read_enb  = 3'b000;
        if (out_valid && bus.out_ready) begin
            read_enb[grant_q] = 1'b1;
        end
        bus.out_valid  = out_valid;
        bus.out_data   = out_valid ? head_g : 8'h00;
        bus.read_enb   = read_enb;
        bus.out_chan   = grant_q;
        bus.soft_reset = soft_reset_q;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.vldout) begin
                    grant_d     = rr_chan;
                    burst_cnt_d = 4'd0;
                    state_d     = StXfer;
                end
            end
            StXfer: begin
                if (!vld_g) begin
                    state_d = StGap;
                end else if (bus.out_ready) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == BurstLast) begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A stalled granted channel keeps counting: only an actual pop proves progress.
    always_comb begin
        wd_cnt_d     = wd_cnt_q;
        soft_reset_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!bus.vldout[i] || read_enb[i]) begin
                wd_cnt_d[i] = 8'd0;
            end else if (wd_cnt_q[i] == WdLast) begin
                wd_cnt_d[i]     = 8'd0;
                soft_reset_d[i] = 1'b1;
            end else begin
                wd_cnt_d[i] = wd_cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
            burst_cnt_q  <= 4'd0;
            wd_cnt_q     <= '0;
            soft_reset_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end
endmodule

// File: tb/tb_router_drain_scheduler.sv
// Bench for router_drain_scheduler: queue-backed FIFOs, transaction-level rotation
// model and cycle-count expectations for the watchdog.
module tb_router_drain_scheduler;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned TIMEOUT   = 30;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_drain_scheduler_if bus ();

    router_drain_scheduler #(
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] fq2[$];

    int errors = 0;
    int checks = 0;

    logic       nxt_rst;
    logic       nxt_ready;
    logic       s_valid, s_ready;
    logic [7:0] s_data;
    logic [2:0] s_re, s_sr;
    logic [1:0] s_chan;

    task automatic drive_inputs();
        rst               = nxt_rst;
        bus.out_ready     = nxt_ready;
        bus.vldout        = {fq2.size() > 0, fq1.size() > 0, fq0.size() > 0};
        bus.data_out_0    = (fq0.size() > 0) ? fq0[0] : 8'h00;
        bus.data_out_1    = (fq1.size() > 0) ? fq1[0] : 8'h00;
        bus.data_out_2    = (fq2.size() > 0) ? fq2[0] : 8'h00;
    endtask

    // Pops follow the strobe seen before the edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_re[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (s_re[1] && fq1.size() > 0) void'(fq1.pop_front());
        if (s_re[2] && fq2.size() > 0) void'(fq2.pop_front());
        drive_inputs();
        @(negedge clk);
        s_valid = bus.out_valid;
        s_ready = bus.out_ready;
        s_data  = bus.out_data;
        s_re    = bus.read_enb;
        s_sr    = bus.soft_reset;
        s_chan  = bus.out_chan;
    endtask

    task automatic do_reset();
        fq0.delete();
        fq1.delete();
        fq2.delete();
        nxt_ready = 1'b0;
        nxt_rst   = 1'b1;
        tick();
        tick();
        nxt_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int n;
        nxt_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_re !== 3'b000 || s_data !== 8'h00 || s_chan !== 2'd0 ||
            s_sr !== 3'b000)
            begin
            errors++;
            $display("FAIL reset_init: valid=%b re=%b data=%h chan=%0d sr=%b, want all zero",
                     s_valid, s_re, s_data, s_chan, s_sr);
        end
        nxt_rst = 1'b0;
        tick();
        for (int j = 0; j < 6; j++) fq1.push_back(8'h11 + 8'(j));
        nxt_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_valid && n < 6);
        checks++;
        if (s_valid !== 1'b1 || s_chan !== 2'd1) begin
            errors++;
            $display("FAIL reset_burst_start: valid=%b chan=%0d, want valid=1 chan=1",
                     s_valid, s_chan);
        end
        tick();
        fq0.push_back(8'hA0);
        fq0.push_back(8'hA1);
        nxt_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_re !== 3'b000 || s_data !== 8'h00 || s_chan !== 2'd0 ||
            s_sr !== 3'b000)
            begin
            errors++;
            $display("FAIL reset_mid_burst: valid=%b re=%b data=%h chan=%0d sr=%b, want zero",
                     s_valid, s_re, s_data, s_chan, s_sr);
        end
        nxt_rst = 1'b0;
        tick();
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_chan !== 2'd0 || s_data !== 8'hA0 || s_re !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b chan=%0d data=%h re=%b, want 1/0/a0/001",
                     s_valid, s_chan, s_data, s_re);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b[3];
        exp_b = '{8'h12, 8'h34, 8'h56};
        do_reset();
        for (int j = 0; j < 3; j++) fq1.push_back(exp_b[j]);
        nxt_ready = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: valid=%b in arrival cycle, want 0", s_valid);
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_data !== exp_b[j] || s_chan !== 2'd1 || s_re !== 3'b010)
                begin
                errors++;
                $display("FAIL single_byte%0d: valid=%b data=%h chan=%0d re=%b, want 1/%h/1/010",
                         j, s_valid, s_data, s_chan, s_re, exp_b[j]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (s_valid !== 1'b0 || s_re !== 3'b000) begin
                errors++;
                $display("FAIL single_after%0d: valid=%b re=%b, want 0/000", j, s_valid, s_re);
            end
        end
    endtask

    // Transaction model: with all data preloaded, bursts rotate from channel 0 and each
    // takes min(MAX_BURST, remaining). Next burst starts 3 cycles after a full burst's
    // last byte, 4 after an early-empty one (the empty XFER cycle adds one).
    task automatic test_burst(input string name, input int n0, input int n1, input int n2,
                              input bit rand_ready);
        logic [7:0] m0[$];
        logic [7:0] m1[$];
        logic [7:0] m2[$];
        logic [1:0] e_ch[$];
        logic [7:0] e_dat[$];
        int         e_gap[$];
        int         rem[3];
        int         last, c, take, k, cyc, last_cyc;
        bit         prev_limit, first;
        logic [7:0] b;
        do_reset();
        for (int j = 0; j < n0; j++) begin b = 8'($urandom); fq0.push_back(b); m0.push_back(b); end
        for (int j = 0; j < n1; j++) begin b = 8'($urandom); fq1.push_back(b); m1.push_back(b); end
        for (int j = 0; j < n2; j++) begin b = 8'($urandom); fq2.push_back(b); m2.push_back(b); end
        rem        = '{n0, n1, n2};
        last       = 2;
        first      = 1'b1;
        prev_limit = 1'b0;
        while (rem[0] + rem[1] + rem[2] > 0) begin
            c = (last + 1) % 3;
            if (rem[c] == 0) c = (c + 1) % 3;
            if (rem[c] == 0) c = (c + 1) % 3;
            take = (rem[c] < int'(MAX_BURST)) ? rem[c] : int'(MAX_BURST);
            for (int j = 0; j < take; j++) begin
                e_ch.push_back(2'(c));
                if (c == 0) e_dat.push_back(m0.pop_front());
                else if (c == 1) e_dat.push_back(m1.pop_front());
                else e_dat.push_back(m2.pop_front());
                e_gap.push_back(j > 0 ? 1 : (first ? 0 : (prev_limit ? 3 : 4)));
            end
            rem[c]     = rem[c] - take;
            prev_limit = (take == int'(MAX_BURST));
            last       = c;
            first      = 1'b0;
        end
        k        = 0;
        cyc      = 0;
        last_cyc = 0;
        while (k < e_ch.size() && cyc < 400) begin
            nxt_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            cyc++;
            if (s_valid && !s_ready) begin
                checks++;
                if (s_re !== 3'b000) begin
                    errors++;
                    $display("FAIL %s_stall_re: re=%b while stalled, want 000", name, s_re);
                end
            end
            if (s_valid && s_ready) begin
                checks++;
                if (s_chan !== e_ch[k] || s_data !== e_dat[k] || s_re !== (3'b001 << e_ch[k]))
                    begin
                    errors++;
                    $display("FAIL %s_xfer%0d: chan=%0d data=%h re=%b, want chan=%0d data=%h",
                             name, k, s_chan, s_data, s_re, e_ch[k], e_dat[k]);
                end
                if (!rand_ready && e_gap[k] != 0) begin
                    checks++;
                    if (cyc - last_cyc != e_gap[k]) begin
                        errors++;
                        $display("FAIL %s_gap%0d: spacing=%0d cycles, want %0d",
                                 name, k, cyc - last_cyc, e_gap[k]);
                    end
                end
                last_cyc = cyc;
                k++;
            end
        end
        checks++;
        if (k != e_ch.size()) begin
            errors++;
            $display("FAIL %s_count: %0d bytes transferred, want %0d", name, k, e_ch.size());
        end
        nxt_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (s_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_drained: valid=%b after all data, want 0", name, s_valid);
            end
        end
    endtask

    task automatic test_burst_limit();
        test_burst("rotation", 6, 6, 6, 1'b0);
    endtask

    task automatic test_early_empty();
        test_burst("early_empty", 2, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            test_burst("random", int'($urandom_range(1, 9)), int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 9)), 1'b1);
        end
    endtask

    task automatic test_stall();
        logic [7:0] b[6];
        int acc, n;
        do_reset();
        for (int j = 0; j < 6; j++) begin
            b[j] = 8'($urandom);
            fq0.push_back(b[j]);
        end
        nxt_ready = 1'b1;
        acc       = 0;
        n         = 0;
        while (acc < 2 && n < 10) begin
            tick();
            n++;
            if (s_valid && s_ready) acc++;
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL stall_setup: %0d bytes accepted, want 2", acc);
        end
        nxt_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_data !== b[2] || s_re !== 3'b000) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b data=%h re=%b, want 1/%h/000",
                         j, s_valid, s_data, s_re, b[2]);
            end
        end
        nxt_ready = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_data !== b[2] || s_re !== 3'b001) begin
            errors++;
            $display("FAIL stall_resume: valid=%b data=%h re=%b, want 1/%h/001",
                     s_valid, s_data, s_re, b[2]);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_data !== b[3] || s_re !== 3'b001) begin
            errors++;
            $display("FAIL stall_fourth: valid=%b data=%h re=%b, want 1/%h/001",
                     s_valid, s_data, s_re, b[3]);
        end
        tick();
        tick();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_gap: valid=%b after burst of 4, want 0", s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_data !== b[4] || s_chan !== 2'd0) begin
            errors++;
            $display("FAIL stall_next_burst: valid=%b data=%h chan=%0d, want 1/%h/0",
                     s_valid, s_data, s_chan, b[4]);
        end
    endtask

    task automatic test_watchdog();
        logic [2:0] exp_sr;
        do_reset();
        fq2.push_back(8'h77);
        nxt_ready = 1'b0;
        tick();
        for (int k = 1; k <= int'(TIMEOUT) + 1; k++) begin
            tick();
            exp_sr = (k == int'(TIMEOUT)) ? 3'b100 : 3'b000;
            checks++;
            if (s_sr !== exp_sr) begin
                errors++;
                $display("FAIL watchdog_cycle%0d: soft_reset=%b, want %b", k, s_sr, exp_sr);
            end
        end
        do_reset();
        fq2.push_back(8'h01);
        fq2.push_back(8'h02);
        nxt_ready = 1'b0;
        tick();
        for (int k = 1; k <= 45; k++) begin
            nxt_ready = (k == 20);
            tick();
            checks++;
            if (s_sr !== 3'b000) begin
                errors++;
                $display("FAIL watchdog_read_cycle%0d: soft_reset=%b, want 000", k, s_sr);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        nxt_rst   = 1'b1;
        nxt_ready = 1'b0;
        s_re      = 3'b000;
        drive_inputs();
        test_reset();
        test_single();
        test_burst_limit();
        test_stall();
        test_early_empty();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
